// File: rtl/tpu_clkgen_pkg.sv
// Shared state encoding and sizing helper for the TPU clock/reset sequencer.
package tpu_clkgen_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2,
        ST_STEP = 2'd3
    } seq_state_t;

    // Bits needed for a counter that runs 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tpu_phase_counter.sv
// Divides CLOCK by HALF_PERIOD: counts 0..HALF_PERIOD-1 while enabled and
// flags the last count so the sequencer can toggle CPU_CLOCK on that edge.
module tpu_phase_counter #(
    parameter int HALF_PERIOD = 1,
    parameter int W           = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(HALF_PERIOD - 1);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    // Phase count: clear has priority, wraps to 0 on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tpu_clock_sequencer.sv
// Clock/reset sequencer for the TEKITO processing unit: holds CPU_RESET low
// for HOLD_CYCLES, then produces a divided, glitch-free CPU_CLOCK under
// run / halt / single-step control, with a cycle counter and optional
// auto-halt after CYCLE_LIMIT CPU clock rises.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_HOLD | CPU_RESET held low, counting out the reset hold
//   ST_IDLE | CPU_CLOCK parked low, waiting for RUN or STEP
//   ST_RUN  | free-running CPU_CLOCK; HALT/limit stop it at a low phase
//   ST_STEP | one full CPU_CLOCK period, then back to ST_IDLE
module tpu_clock_sequencer
    import tpu_clkgen_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int HALF_PERIOD = 1,
    parameter int CNT_W       = 16,
    parameter int CYCLE_LIMIT = 0,
    parameter int AUTO_RUN    = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             HALT,
    input  logic             STEP,
    output logic             CPU_CLOCK,
    output logic             CPU_RESET,
    output logic [CNT_W-1:0] CYCLE_COUNT,
    output logic             RUNNING,
    output logic             LIMIT_HIT
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int PH_W   = cnt_width(HALF_PERIOD);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LIMIT_VAL = CNT_W'(CYCLE_LIMIT);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("tpu_clock_sequencer: HOLD_CYCLES must be at least 1");
    end
    if (HALF_PERIOD < 1) begin : g_bad_half
        $error("tpu_clock_sequencer: HALF_PERIOD must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("tpu_clock_sequencer: CNT_W must be at least 1");
    end
    if (CYCLE_LIMIT < 0 || (CNT_W < 31 && CYCLE_LIMIT > (1 << CNT_W) - 1)) begin : g_bad_limit
        $error("tpu_clock_sequencer: CYCLE_LIMIT does not fit in CYCLE_COUNT");
    end

    seq_state_t        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              cpu_clock, cpu_clock_nxt;
    logic              cpu_reset, cpu_reset_nxt;
    logic              running, running_nxt;
    logic              limit_hit, limit_nxt;
    logic              halt_pending, pending_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [CNT_W-1:0]  count_inc;
    logic              limit_reached;
    logic              phase_en;
    logic              phase_clr;
    logic              tc;

    // The divider only runs while a clock is being produced; a halt taken
    // in the low phase restarts the next run from a fresh phase.
    assign phase_en  = (state == ST_RUN) || (state == ST_STEP);
    assign phase_clr = !phase_en || ((state == ST_RUN) && !cpu_clock && HALT);

    assign count_inc     = count + 1'b1;
    assign limit_reached = (CYCLE_LIMIT != 0) && (count_inc == LIMIT_VAL);

    tpu_phase_counter #(
        .HALF_PERIOD (HALF_PERIOD),
        .W           (PH_W)
    ) u_phase (
        .clk   (CLOCK),
        .rst_n (RESET),
        .en    (phase_en),
        .clr   (phase_clr),
        .tc    (tc)
    );

    // State and every output are registered together so they never skew.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state        <= ST_HOLD;
            hold_cnt     <= '0;
            cpu_clock    <= 1'b0;
            cpu_reset    <= 1'b0;
            running      <= 1'b0;
            limit_hit    <= 1'b0;
            halt_pending <= 1'b0;
            count        <= '0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            cpu_clock    <= cpu_clock_nxt;
            cpu_reset    <= cpu_reset_nxt;
            running      <= running_nxt;
            limit_hit    <= limit_nxt;
            halt_pending <= pending_nxt;
            count        <= count_nxt;
        end
    end

    // Next-state logic: clock edges only on the divider terminal count, and
    // a high phase always runs to completion before stopping.
    always_comb begin
        state_nxt     = state;
        hold_nxt      = hold_cnt;
        cpu_clock_nxt = cpu_clock;
        cpu_reset_nxt = cpu_reset;
        running_nxt   = running;
        limit_nxt     = limit_hit;
        pending_nxt   = halt_pending;
        count_nxt     = count;

        unique case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    cpu_reset_nxt = 1'b1;
                    if (AUTO_RUN != 0) begin
                        state_nxt   = ST_RUN;
                        running_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end

            ST_IDLE: begin
                cpu_clock_nxt = 1'b0;
                // Once the limit has fired only a reset restarts the CPU.
                if (!HALT && !limit_hit) begin
                    if (STEP) begin
                        state_nxt   = ST_STEP;
                        running_nxt = 1'b1;
                    end else if (RUN) begin
                        state_nxt   = ST_RUN;
                        running_nxt = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (!cpu_clock) begin
                    if (HALT) begin
                        state_nxt   = ST_IDLE;
                        running_nxt = 1'b0;
                    end else if (tc) begin
                        cpu_clock_nxt = 1'b1;
                        count_nxt     = count_inc;
                        if (limit_reached) begin
                            limit_nxt   = 1'b1;
                            pending_nxt = 1'b1;
                        end
                    end
                end else if (tc) begin
                    cpu_clock_nxt = 1'b0;
                    if (halt_pending || HALT) begin
                        state_nxt   = ST_IDLE;
                        running_nxt = 1'b0;
                        pending_nxt = 1'b0;
                    end
                end else if (HALT) begin
                    pending_nxt = 1'b1;
                end
            end

            ST_STEP: begin
                if (tc) begin
                    if (!cpu_clock) begin
                        cpu_clock_nxt = 1'b1;
                        count_nxt     = count_inc;
                        if (limit_reached) begin
                            limit_nxt = 1'b1;
                        end
                    end else begin
                        cpu_clock_nxt = 1'b0;
                        state_nxt     = ST_IDLE;
                        running_nxt   = 1'b0;
                    end
                end
            end
        endcase
    end

    assign CPU_CLOCK   = cpu_clock;
    assign CPU_RESET   = cpu_reset;
    assign CYCLE_COUNT = count;
    assign RUNNING     = running;
    assign LIMIT_HIT   = limit_hit;

endmodule

// File: tb/tb_tpu_clock_sequencer.sv
// Bench for tpu_clock_sequencer: five instances with different parameters.
// Expected CPU_CLOCK toggles (tick, level, count) are queued per instance by
// the stimulus; a negedge monitor pops one entry for every observed toggle.
module tb_tpu_clock_sequencer;

    localparam int N = 5;   // 0 default, 1 HALF_PERIOD=3, 2 AUTO_RUN=0, 3 CYCLE_LIMIT=5, 4 CNT_W=3

    typedef struct {
        int   tick;
        logic level;
        int   count;
    } exp_t;

    logic         clk = 1'b0;
    logic [N-1:0] rst_n;
    logic [N-1:0] run;
    logic [N-1:0] halt;
    logic [N-1:0] step;
    wire  [N-1:0] cpu_clk;
    wire  [N-1:0] cpu_rst;
    wire  [N-1:0] running;
    wire  [N-1:0] limit_hit;
    wire  [15:0]  cnt_a, cnt_b, cnt_c, cnt_d;
    wire  [2:0]   cnt_e;
    int           cnt_v [N];

    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    exp_t         exp_q [N][$];
    logic [N-1:0] prev_clk = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        cnt_v[0] = int'(cnt_a);
        cnt_v[1] = int'(cnt_b);
        cnt_v[2] = int'(cnt_c);
        cnt_v[3] = int'(cnt_d);
        cnt_v[4] = int'(cnt_e);
    end

    tpu_clock_sequencer u_a (
        .CLOCK(clk), .RESET(rst_n[0]), .RUN(run[0]), .HALT(halt[0]), .STEP(step[0]),
        .CPU_CLOCK(cpu_clk[0]), .CPU_RESET(cpu_rst[0]), .CYCLE_COUNT(cnt_a),
        .RUNNING(running[0]), .LIMIT_HIT(limit_hit[0]));

    tpu_clock_sequencer #(.HALF_PERIOD(3)) u_b (
        .CLOCK(clk), .RESET(rst_n[1]), .RUN(run[1]), .HALT(halt[1]), .STEP(step[1]),
        .CPU_CLOCK(cpu_clk[1]), .CPU_RESET(cpu_rst[1]), .CYCLE_COUNT(cnt_b),
        .RUNNING(running[1]), .LIMIT_HIT(limit_hit[1]));

    tpu_clock_sequencer #(.AUTO_RUN(0)) u_c (
        .CLOCK(clk), .RESET(rst_n[2]), .RUN(run[2]), .HALT(halt[2]), .STEP(step[2]),
        .CPU_CLOCK(cpu_clk[2]), .CPU_RESET(cpu_rst[2]), .CYCLE_COUNT(cnt_c),
        .RUNNING(running[2]), .LIMIT_HIT(limit_hit[2]));

    tpu_clock_sequencer #(.CYCLE_LIMIT(5)) u_d (
        .CLOCK(clk), .RESET(rst_n[3]), .RUN(run[3]), .HALT(halt[3]), .STEP(step[3]),
        .CPU_CLOCK(cpu_clk[3]), .CPU_RESET(cpu_rst[3]), .CYCLE_COUNT(cnt_d),
        .RUNNING(running[3]), .LIMIT_HIT(limit_hit[3]));

    tpu_clock_sequencer #(.CNT_W(3)) u_e (
        .CLOCK(clk), .RESET(rst_n[4]), .RUN(run[4]), .HALT(halt[4]), .STEP(step[4]),
        .CPU_CLOCK(cpu_clk[4]), .CPU_RESET(cpu_rst[4]), .CYCLE_COUNT(cnt_e),
        .RUNNING(running[4]), .LIMIT_HIT(limit_hit[4]));

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s [inst %0d] tick %0d: got %0d, expected %0d",
                     name, inst, cyc, act, exp);
        end
    endtask

    // Returns at the negedge following posedge number t.
    task automatic wait_tick(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push(input int inst, input int tick, input logic level, input int count);
        exp_t e;
        e.tick  = tick;
        e.level = level;
        e.count = count;
        exp_q[inst].push_back(e);
    endtask

    // Rises k_first..k_last, first rise at first_rise, each high for 'half' ticks.
    task automatic push_run(input int inst, input int first_rise, input int half,
                            input int k_first, input int k_last, input int wrap);
        for (int k = k_first; k <= k_last; k++) begin
            int t;
            t = first_rise + (k - k_first) * 2 * half;
            push(inst, t, 1'b1, k % wrap);
            push(inst, t + half, 1'b0, k % wrap);
        end
    endtask

    // Toggle monitor: every CPU_CLOCK change must match the next queued entry.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (cpu_clk[i] !== prev_clk[i]) begin
                if (exp_q[i].size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_toggle [inst %0d] tick %0d: CPU_CLOCK went to %0b, none expected",
                             i, cyc, cpu_clk[i]);
                end else begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    check("toggle_tick", i, cyc, e.tick);
                    check("toggle_level", i, int'(cpu_clk[i]), int'(e.level));
                    check("toggle_count", i, cnt_v[i], e.count);
                end
                prev_clk[i] = cpu_clk[i];
            end
        end
    end

    initial begin
        rst_n = '1;
        run   = '0;
        halt  = '0;
        step  = '0;

        // Inst 0: run enters at tick 6, rises every other tick, halted after rise 50;
        // later reset mid-high at 122, restarts and is halted after one rise.
        push_run(0, 7, 1, 1, 50, 65536);
        push(0, 122, 1'b1, 51);
        push(0, 123, 1'b0, 0);
        push_run(0, 130, 1, 1, 1, 65536);
        // Inst 1: 3/3 duty, halt pending through a high phase, resumed at 31.
        push_run(1, 9, 3, 1, 2, 65536);
        push_run(1, 34, 3, 3, 3, 65536);
        // Inst 2: two single steps only.
        push_run(2, 12, 1, 1, 1, 65536);
        push_run(2, 22, 1, 2, 2, 65536);
        // Inst 3: stops after 5 rises.
        push_run(3, 7, 1, 1, 5, 65536);
        // Inst 4: 3-bit count wraps 7 -> 0 on rise 8.
        push_run(4, 7, 1, 1, 9, 8);

        #1 rst_n = '0;
        #1;
        for (int i = 0; i < N; i++) begin
            check("rst_cpu_clock", i, int'(cpu_clk[i]), 0);
            check("rst_cpu_reset", i, int'(cpu_rst[i]), 0);
            check("rst_running", i, int'(running[i]), 0);
            check("rst_limit_hit", i, int'(limit_hit[i]), 0);
            check("rst_count", i, cnt_v[i], 0);
        end

        wait_tick(2);
        rst_n = '1;
        wait_tick(5);
        for (int i = 0; i < N; i++) check("hold_cpu_reset_low", i, int'(cpu_rst[i]), 0);
        wait_tick(6);
        for (int i = 0; i < N; i++) check("hold_cpu_reset_high", i, int'(cpu_rst[i]), 1);
        check("autorun_running", 0, int'(running[0]), 1);
        check("idle_running", 2, int'(running[2]), 0);
        wait_tick(8);
        check("idle_cpu_clock", 2, int'(cpu_clk[2]), 0);
        check("idle_running", 2, int'(running[2]), 0);
        wait_tick(10);
        step[2] = 1'b1;
        wait_tick(11);
        step[2] = 1'b0;
        check("step_running", 2, int'(running[2]), 1);
        wait_tick(13);
        check("step_done_running", 2, int'(running[2]), 0);
        wait_tick(14);
        check("limit_before", 3, int'(limit_hit[3]), 0);
        wait_tick(15);
        check("limit_at_5th_rise", 3, int'(limit_hit[3]), 1);
        halt[1] = 1'b1;
        wait_tick(16);
        halt[1] = 1'b0;
        wait_tick(17);
        check("limit_idle_running", 3, int'(running[3]), 0);
        check("limit_idle_clock", 3, int'(cpu_clk[3]), 0);
        wait_tick(18);
        check("halt_high_running", 1, int'(running[1]), 0);
        wait_tick(20);
        step[2] = 1'b1;
        run[2]  = 1'b1;
        run[3]  = 1'b1;
        wait_tick(21);
        step[2] = 1'b0;
        run[2]  = 1'b0;
        wait_tick(22);
        check("wrap_count", 4, cnt_v[4], 0);
        wait_tick(24);
        halt[4] = 1'b1;
        check("halt_frozen_count", 1, cnt_v[1], 2);
        check("halt_frozen_clock", 1, int'(cpu_clk[1]), 0);
        wait_tick(25);
        halt[4] = 1'b0;
        wait_tick(26);
        check("wrap_count_after", 4, cnt_v[4], 1);
        check("wrap_halt_running", 4, int'(running[4]), 0);
        wait_tick(28);
        check("step_run_count", 2, cnt_v[2], 2);
        check("step_run_running", 2, int'(running[2]), 0);
        wait_tick(30);
        halt[2] = 1'b1;
        step[2] = 1'b1;
        run[1]  = 1'b1;
        step[3] = 1'b1;
        wait_tick(31);
        halt[2] = 1'b0;
        step[2] = 1'b0;
        run[1]  = 1'b0;
        wait_tick(34);
        check("halt_step_count", 2, cnt_v[2], 2);
        check("halt_step_running", 2, int'(running[2]), 0);
        wait_tick(35);
        step[3] = 1'b0;
        wait_tick(37);
        halt[1] = 1'b1;
        wait_tick(38);
        halt[1] = 1'b0;
        check("halt_low_running", 1, int'(running[1]), 0);
        wait_tick(40);
        run[3] = 1'b0;
        check("limit_count", 3, cnt_v[3], 5);
        check("limit_sticky", 3, int'(limit_hit[3]), 1);
        check("limit_ignores_run", 3, int'(running[3]), 0);
        check("resume_count", 1, cnt_v[1], 3);

        wait_tick(106);
        check("count_after_100", 0, cnt_v[0], 50);
        halt[0] = 1'b1;
        wait_tick(107);
        halt[0] = 1'b0;
        check("halt_low_running", 0, int'(running[0]), 0);
        wait_tick(110);
        check("halt_frozen_count", 0, cnt_v[0], 50);
        wait_tick(120);
        run[0] = 1'b1;
        wait_tick(122);
        check("pre_reset_clock", 0, int'(cpu_clk[0]), 1);
        #1 rst_n[0] = 1'b0;
        #1;
        check("async_rst_cpu_clock", 0, int'(cpu_clk[0]), 0);
        check("async_rst_cpu_reset", 0, int'(cpu_rst[0]), 0);
        check("async_rst_running", 0, int'(running[0]), 0);
        check("async_rst_limit_hit", 0, int'(limit_hit[0]), 0);
        check("async_rst_count", 0, cnt_v[0], 0);
        wait_tick(123);
        run[0] = 1'b0;
        wait_tick(125);
        rst_n[0] = 1'b1;
        wait_tick(128);
        check("rehold_cpu_reset_low", 0, int'(cpu_rst[0]), 0);
        check("rehold_running", 0, int'(running[0]), 0);
        wait_tick(129);
        check("rehold_cpu_reset_high", 0, int'(cpu_rst[0]), 1);
        wait_tick(130);
        halt[0] = 1'b1;
        wait_tick(131);
        halt[0] = 1'b0;
        check("final_halt_running", 0, int'(running[0]), 0);

        wait_tick(140);
        for (int i = 0; i < N; i++) check("missing_toggles", i, exp_q[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tpu_clock_sequencer.md
Name: tpu_clock_sequencer

Overview:
Parametrised clock/reset sequencer for the TEKITO processing unit. It generalises the fixed scheme of a 4-cycle reset hold followed by a free-running divide-by-2 CPU clock. It adds a programmable reset hold, a programmable divide ratio, run/halt/single-step control, a CPU cycle counter and an optional cycle-limit auto-halt. It sits between the board oscillator and the TPU's CLOCK/RESET pins, and is also used in the simulation harness.

Parameters:
HOLD_CYCLES, 4, CLOCK posedges CPU_RESET stays low after RESET deasserts (legal >=1).
HALF_PERIOD, 1, CLOCK posedges per CPU_CLOCK phase (legal >=1).
CNT_W, 16, width of CYCLE_COUNT.
CYCLE_LIMIT, 0, auto-halt after this many CPU_CLOCK rising edges; 0 = unlimited.
AUTO_RUN, 1, 1: enter RUN after hold; 0: enter IDLE and wait for RUN/STEP.

Ports:
CLOCK  in  1  oscillator; all logic on posedge.
RESET  in  1  asynchronous, active-low; deassertion synchronous to CLOCK by the environment.
RUN  in  1  level, sampled on CLOCK; start free-running.
HALT  in  1  level, sampled on CLOCK; stop at next low phase.
STEP  in  1  level, sampled on CLOCK; emit exactly one CPU clock period.
CPU_CLOCK  out  1  registered, glitch-free CPU clock.
CPU_RESET  out  1  registered, active-low CPU reset.
CYCLE_COUNT  out  CNT_W  number of CPU_CLOCK rising edges since reset.
RUNNING  out  1  1 in RUN or STEP state.
LIMIT_HIT  out  1  sticky; CYCLE_LIMIT reached.

Behaviour:
- Reset (RESET=0, asynchronous): state HOLD; hold counter, phase counter and CYCLE_COUNT = 0; CPU_CLOCK=0, CPU_RESET=0, RUNNING=0, LIMIT_HIT=0. Outputs change immediately, without a CLOCK edge.
- States: HOLD, IDLE, RUN, STEP, plus an internal halt_pending flag.
- HOLD: hold counter increments each posedge. On the HOLD_CYCLES-th posedge after RESET rises:
  - CPU_RESET<=1;
  - state<=RUN if AUTO_RUN, else IDLE.
- RUN/STEP: the phase counter counts 0..HALF_PERIOD-1. At the terminal count it toggles CPU_CLOCK and clears.
  - First toggle occurs HALF_PERIOD posedges after entering the state.
  - Duty cycle is exactly 50%.
- CYCLE_COUNT increments on the posedge where CPU_CLOCK goes 0->1. It wraps modulo 2^CNT_W.
- IDLE: CPU_CLOCK held 0, phase counter held 0. Input priority: HALT > STEP > RUN.
  - HALT suppresses both other inputs.
  - STEP -> STEP state.
  - RUN (alone) -> RUN state.
- STEP: one full period (HALF_PERIOD low, HALF_PERIOD high), then IDLE on the falling-toggle edge. RUN/STEP/HALT are ignored during STEP.
- HALT in RUN:
  - CPU_CLOCK low: -> IDLE on the same edge, phase cleared.
  - CPU_CLOCK high: set halt_pending; complete the high phase; -> IDLE on the falling-toggle edge.
  - A high phase is never truncated.
- CYCLE_LIMIT!=0, on the rising edge that makes CYCLE_COUNT==CYCLE_LIMIT:
  - LIMIT_HIT<=1;
  - finish the high phase, then IDLE;
  - RUN/STEP are ignored until RESET.
- RUNNING is registered alongside the state. It is 0 from the edge that enters IDLE.
- A RESET mid-phase aborts everything; there are no partial-state leftovers.
- CYCLE_LIMIT > 2^CNT_W-1 is an elaboration error. HOLD_CYCLES=0 or HALF_PERIOD=0 is an elaboration error.

Decomposition:
- Package tpu_clkgen_pkg: state encoding constants (ST_HOLD, ST_IDLE, ST_RUN, ST_STEP), counter-width helper function (clog2 of HOLD_CYCLES/HALF_PERIOD).
- One sub-module, tpu_phase_counter:
  - HALF_PERIOD divider with enable and synchronous clear;
  - outputs a terminal pulse;
  - async active-low reset.
- The sequencer FSM, counters and limit logic stay in the top module.

Test Plan:
1. Defaults; RESET low 2 cycles then high -> CPU_RESET rises on 4th posedge; CPU_CLOCK toggles every posedge thereafter; CYCLE_COUNT=1 after first rise, =50 after 100 posedges of running.
2. HALF_PERIOD=3 -> CPU_CLOCK period 6 CLOCK cycles, 3 high/3 low; first rise 3 posedges after CPU_RESET rises.
3. HALF_PERIOD=3, HALT asserted 1 cycle into a high phase -> high lasts full 3 cycles, then CPU_CLOCK=0, RUNNING=0, CYCLE_COUNT frozen; later RUN resumes counting from the same value.
4. AUTO_RUN=0 -> IDLE after hold, CPU_CLOCK=0.
   - STEP for 1 cycle -> exactly one 1-cycle high pulse, count=1.
   - STEP+RUN together -> single step only.
   - HALT+STEP together -> nothing.
5. CYCLE_LIMIT=5 -> LIMIT_HIT set on 5th rise; CPU_CLOCK falls after, stays 0; RUN/STEP ignored; CYCLE_COUNT=5. CNT_W=3, CYCLE_LIMIT=0 -> count wraps 7->0.
6. RESET pulled low mid high phase -> CPU_CLOCK, CPU_RESET, RUNNING, LIMIT_HIT, CYCLE_COUNT all 0 before next CLOCK edge; hold sequence restarts on release.
